spu_regfile: RTL
================

// Module: spu_regfile
// PURPOSE
//  Unified 128 x 128-bit SPU register file, directly downstream of the MEM/WB pipeline register.
//  Consumes both writeback streams: even pipe (_e) and odd pipe (_o).
//  Serves six combinational read ports to decode: ra/rb/rc for each pipe, with same-cycle WB bypass.
//  A post-reset clear sequencer zeroes the array one entry per cycle.
//  While clearing, it holds the pipeline via stallreq_rf.
// PARAMETERS
//  DATA_W   128  register width in bits
//  ADDR_W   7    register address width
//  DEPTH    128  number of registers (2**ADDR_W)
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst            in   1       reset rst, synchronous, active-high
//  wb_wreg_e      in   1       even-pipe write enable (from MEM/WB)
//  wb_rtaddr_e    in   ADDR_W  even-pipe write address
//  wb_rt_e        in   DATA_W  even-pipe write data
//  wb_wreg_o      in   1       odd-pipe write enable
//  wb_rtaddr_o    in   ADDR_W  odd-pipe write address
//  wb_rt_o        in   DATA_W  odd-pipe write data
//  re_{ra,rb,rc}_{e,o}    in   1       read enable, one per read port (6 ports)
//  addr_{ra,rb,rc}_{e,o}  in   ADDR_W  read address per port
//  data_{ra,rb,rc}_{e,o}  out  DATA_W  read data per port (combinational)
//  rf_ready       out  1       1 = array initialised, normal operation
//  stallreq_rf    out  1       stall request to pipeline control; equals ~rf_ready
// BEHAVIOUR
//  FSM states: CLEAR, READY; clear counter clr_cnt is ADDR_W+1 bits wide.
//  Reset: rst=1 at a posedge -> state=CLEAR, clr_cnt=0, rf_ready=0, stallreq_rf=1.
//   This holds from any state, including mid-clear, which restarts the sweep at entry 0.
//  CLEAR: each cycle writes 0 to reg[clr_cnt] and increments clr_cnt.
//   Once the write to entry DEPTH-1 completes (clr_cnt==DEPTH), go to READY.
//   CLEAR therefore lasts exactly DEPTH cycles after rst deasserts.
//   rf_ready rises on the DEPTH-th posedge after rst deasserts.
//  CLEAR: wb writes are ignored, and all data_* outputs are 0 regardless of re_*.
//  READY: on posedge, if wb_wreg_e then reg[wb_rtaddr_e] <= wb_rt_e.
//   Likewise, if wb_wreg_o then reg[wb_rtaddr_o] <= wb_rt_o.
//  Same-address dual write (both wreg, equal addr): the odd-pipe value is stored.
//   Odd is later in program order. The even write is dropped.
//  Read, per port, priority order (READY state):
//   1) re=0 -> data = 0
//   2) wb_wreg_o && addr == wb_rtaddr_o -> data = wb_rt_o (bypass)
//   3) wb_wreg_e && addr == wb_rtaddr_e -> data = wb_rt_e (bypass)
//   4) otherwise data = reg[addr]
//  Bypass gives zero-cycle latency from WB to decode. Array write latency is 1 cycle.
//  All six read ports are independent; any number may share an address.
//  No address is special: register 0 is writable and readable like any other.
//  Write enable alone gates writes; a NOP writeback uses wreg=0.
//  Reset values: rf_ready=0, stallreq_rf=1, data_*=0.
//   Array contents are undefined until CLEAR completes, then all 0.
// TESTING
//  T1 reset/clear: pulse rst 1 cycle, then read all 128 addrs on all ports.
//   -> stallreq_rf=1 for exactly 128 cycles; afterwards every read = 0.
//  T2 rst mid-clear: assert rst at clr_cnt=60.
//   -> rf_ready stays 0 for a further 128 cycles; entries 0..127 read 0.
//  T3 write/read: even writes r5=0xA5..A5, odd writes r9=0x3C..3C.
//   -> next cycle data_ra_e(5)=0xA5..A5 and data_rb_o(9)=0x3C..3C.
//  T4 bypass: wb_wreg_e=1, addr=17, data=0x1234 with addr_rc_o=17 in the same cycle.
//   -> data_rc_o=0x1234 combinationally, before the posedge.
//  T5 dual write collision: both pipes write r42 (e=0x1111, o=0x2222).
//   -> same-cycle read of r42 = 0x2222; after the posedge the stored value = 0x2222.
//  T6 writes during clear: wb_wreg_e=1 to r3 while in CLEAR.
//   -> no effect; r3 reads 0 after rf_ready=1.

Source files
------------

// File: rtl/spu_regfile.sv
// -----------------------------------------------------------------------------
// spu_regfile
//   Unified 128 x 128-bit SPU register file sitting directly after the MEM/WB
//   pipeline register. It accepts two writeback streams: the even pipe (_e)
//   and the odd pipe (_o). It serves six combinational read ports to decode
//   (ra/rb/rc for each pipe), with same-cycle writeback bypass.
//
//   After reset a clear sequencer zeroes one entry per cycle. While it runs,
//   the pipeline is held through stallreq_rf, writebacks are ignored and
//   every read port returns 0.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   wb_wreg_{e,o}             writeback enable per pipe
//   wb_rtaddr_{e,o}           writeback address per pipe
//   wb_rt_{e,o}               writeback data per pipe
//   re_{ra,rb,rc}_{e,o}       read enable per read port
//   addr_{ra,rb,rc}_{e,o}     read address per read port
//   data_{ra,rb,rc}_{e,o}     read data per read port (combinational)
//   rf_ready                  1 once the array has been cleared
//   stallreq_rf               stall request to pipeline control (~rf_ready)
// -----------------------------------------------------------------------------
module spu_regfile #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              wb_wreg_e,
    input  logic [ADDR_W-1:0] wb_rtaddr_e,
    input  logic [DATA_W-1:0] wb_rt_e,
    input  logic              wb_wreg_o,
    input  logic [ADDR_W-1:0] wb_rtaddr_o,
    input  logic [DATA_W-1:0] wb_rt_o,

    input  logic              re_ra_e,
    input  logic              re_rb_e,
    input  logic              re_rc_e,
    input  logic              re_ra_o,
    input  logic              re_rb_o,
    input  logic              re_rc_o,
    input  logic [ADDR_W-1:0] addr_ra_e,
    input  logic [ADDR_W-1:0] addr_rb_e,
    input  logic [ADDR_W-1:0] addr_rc_e,
    input  logic [ADDR_W-1:0] addr_ra_o,
    input  logic [ADDR_W-1:0] addr_rb_o,
    input  logic [ADDR_W-1:0] addr_rc_o,
    output logic [DATA_W-1:0] data_ra_e,
    output logic [DATA_W-1:0] data_rb_e,
    output logic [DATA_W-1:0] data_rc_e,
    output logic [DATA_W-1:0] data_ra_o,
    output logic [DATA_W-1:0] data_rb_o,
    output logic [DATA_W-1:0] data_rc_o,

    output logic              rf_ready,
    output logic              stallreq_rf
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W:0]   clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    // Control: clear sequencer. rf_ready rises on the same edge that writes
    // the last entry, so the sweep takes exactly DEPTH cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            rf_ready <= 1'b0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == CNT_LAST) begin
                state    <= READY;
                rf_ready <= 1'b1;
            end
        end
    end

    assign stallreq_rf = ~rf_ready;

    // Array: data storage is not reset; the sweep is what initialises it.
    // The odd write is issued after the even one so it wins on a same-address
    // collision (odd is later in program order).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt[ADDR_W-1:0]] <= '0;
            end else begin
                if (wb_wreg_e) mem[wb_rtaddr_e] <= wb_rt_e;
                if (wb_wreg_o) mem[wb_rtaddr_o] <= wb_rt_o;
            end
        end
    end

    // Read ports: index 0..2 = ra/rb/rc even, 3..5 = ra/rb/rc odd.
    logic [5:0]        re_v;
    logic [ADDR_W-1:0] addr_v [6];

    assign re_v      = {re_rc_o, re_rb_o, re_ra_o, re_rc_e, re_rb_e, re_ra_e};
    assign addr_v[0] = addr_ra_e;
    assign addr_v[1] = addr_rb_e;
    assign addr_v[2] = addr_rc_e;
    assign addr_v[3] = addr_ra_o;
    assign addr_v[4] = addr_rb_o;
    assign addr_v[5] = addr_rc_o;

    for (genvar p = 0; p < 6; p++) begin : g_rd
        logic [DATA_W-1:0] rd;
        // Odd bypass beats even bypass, matching the array collision rule.
        always_comb begin
            rd = '0;
            if (state == READY && re_v[p]) begin
                if (wb_wreg_o && addr_v[p] == wb_rtaddr_o)
                    rd = wb_rt_o;
                else if (wb_wreg_e && addr_v[p] == wb_rtaddr_e)
                    rd = wb_rt_e;
                else
                    rd = mem[addr_v[p]];
            end
        end
    end

    assign data_ra_e = g_rd[0].rd;
    assign data_rb_e = g_rd[1].rd;
    assign data_rc_e = g_rd[2].rd;
    assign data_ra_o = g_rd[3].rd;
    assign data_rb_o = g_rd[4].rd;
    assign data_rc_o = g_rd[5].rd;

endmodule
